// File: rtl/tone_pkg.sv
// Shared constants for the tone decoder: note table, special note codes and
// classifier state encoding.
package tone_pkg;

    localparam int NOTE_COUNT = 24;

    localparam logic [4:0] NOTE_UNKNOWN = 5'd30;
    localparam logic [4:0] NOTE_SILENCE = 5'd31;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SCAN   = 2'd1;
    localparam state_t ST_REPORT = 2'd2;

    // Nominal pitches C_6..B_7 in Hz, same values the player uses.
    function automatic logic [13:0] note_hz(input logic [4:0] idx);
        case (idx)
            5'd0:    note_hz = 14'd1047;
            5'd1:    note_hz = 14'd1109;
            5'd2:    note_hz = 14'd1175;
            5'd3:    note_hz = 14'd1245;
            5'd4:    note_hz = 14'd1319;
            5'd5:    note_hz = 14'd1397;
            5'd6:    note_hz = 14'd1480;
            5'd7:    note_hz = 14'd1568;
            5'd8:    note_hz = 14'd1661;
            5'd9:    note_hz = 14'd1760;
            5'd10:   note_hz = 14'd1865;
            5'd11:   note_hz = 14'd1976;
            5'd12:   note_hz = 14'd2093;
            5'd13:   note_hz = 14'd2217;
            5'd14:   note_hz = 14'd2349;
            5'd15:   note_hz = 14'd2489;
            5'd16:   note_hz = 14'd2637;
            5'd17:   note_hz = 14'd2794;
            5'd18:   note_hz = 14'd2960;
            5'd19:   note_hz = 14'd3136;
            5'd20:   note_hz = 14'd3322;
            5'd21:   note_hz = 14'd3520;
            5'd22:   note_hz = 14'd3729;
            5'd23:   note_hz = 14'd3951;
            default: note_hz = 14'd0;
        endcase
    endfunction

    function automatic logic [13:0] abs_diff(input logic [13:0] a, input logic [13:0] b);
        abs_diff = (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/tone_gate_timer.sv
// Tick chain: 1 us tick every CLK_MHZ clocks, 1 ms tick every 1000 us, and a
// single-cycle gate_end on every GATE_MS-th ms tick.
module tone_gate_timer #(
    parameter int CLK_MHZ = 125,
    parameter int GATE_MS = 100
) (
    input  logic clk,
    input  logic reset_p,
    output logic gate_end
);

    localparam int US_W = $clog2(CLK_MHZ + 1);
    localparam int GT_W = $clog2(GATE_MS + 1);

    logic [US_W-1:0] us_cnt;
    logic [9:0]      ms_cnt;
    logic [GT_W-1:0] gate_cnt;
    logic            us_tick;
    logic            ms_tick;

    assign us_tick  = (us_cnt == US_W'(CLK_MHZ - 1));
    assign ms_tick  = us_tick && (ms_cnt == 10'd999);
    assign gate_end = ms_tick && (gate_cnt == GT_W'(GATE_MS - 1));

    always_ff @(posedge clk) begin
        if (reset_p) begin
            us_cnt   <= '0;
            ms_cnt   <= '0;
            gate_cnt <= '0;
        end else begin
            us_cnt <= us_tick ? '0 : us_cnt + 1'b1;
            if (us_tick) begin
                ms_cnt <= ms_tick ? '0 : ms_cnt + 1'b1;
            end
            if (ms_tick) begin
                gate_cnt <= gate_end ? '0 : gate_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tone_decoder.sv
// Measures the frequency of a square-wave tone over fixed gates, classifies it
// against the note table and reports the length of each run of identical notes.
module tone_decoder
    import tone_pkg::*;
#(
    parameter int CLK_MHZ = 125,
    parameter int GATE_MS = 100,
    parameter int TOL_HZ  = 30
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic        song_in,
    output logic [13:0] freq_hz,
    output logic        freq_valid,
    output logic        freq_sat,
    output logic [4:0]  note_idx,
    output logic        cls_valid,
    output logic        evt_valid,
    output logic [4:0]  evt_idx,
    output logic [15:0] evt_dur_ms
);

    localparam int         FREQ_MULT = 1000 / GATE_MS;
    localparam logic [9:0] CNT_MAX   = 10'd1023;

    logic        gate_end;
    logic        sync_q1;
    logic        sync_q2;
    logic        rise;
    logic [9:0]  edge_cnt;
    logic [9:0]  cnt_final;
    logic [13:0] freq_next;

    state_t      state;
    logic [4:0]  scan_i;
    logic        found;
    logic [4:0]  match_idx;
    logic [4:0]  cur_idx;
    logic [15:0] run_ms;
    logic        hit;
    logic        scan_last;
    logic [4:0]  result;
    logic [16:0] run_sum;
    logic [15:0] run_inc;

    tone_gate_timer #(
        .CLK_MHZ(CLK_MHZ),
        .GATE_MS(GATE_MS)
    ) u_timer (
        .clk     (clk),
        .reset_p (reset_p),
        .gate_end(gate_end)
    );

    // An edge seen on the gate-end cycle still belongs to the closing gate.
    assign rise      = sync_q1 & ~sync_q2;
    assign cnt_final = (rise && (edge_cnt != CNT_MAX)) ? edge_cnt + 10'd1 : edge_cnt;
    assign freq_next = 14'(cnt_final * FREQ_MULT);

    always_ff @(posedge clk) begin
        if (reset_p) begin
            sync_q1    <= 1'b0;
            sync_q2    <= 1'b0;
            edge_cnt   <= '0;
            freq_hz    <= '0;
            freq_sat   <= 1'b0;
            freq_valid <= 1'b0;
        end else begin
            sync_q1    <= song_in;
            sync_q2    <= sync_q1;
            freq_valid <= gate_end;
            if (gate_end) begin
                edge_cnt <= '0;
                freq_hz  <= freq_next;
                freq_sat <= (cnt_final == CNT_MAX);
            end else begin
                edge_cnt <= cnt_final;
            end
        end
    end

    assign hit       = (abs_diff(freq_hz, note_hz(scan_i)) <= 14'(TOL_HZ));
    assign scan_last = (scan_i == 5'(NOTE_COUNT - 1));
    assign run_sum   = {1'b0, run_ms} + 17'(GATE_MS);
    assign run_inc   = run_sum[16] ? 16'hFFFF : run_sum[15:0];

    // Only consumed on the last scan cycle, when found covers all lower entries.
    always_comb begin
        result = NOTE_UNKNOWN;
        if (freq_hz == 14'd0) begin
            result = NOTE_SILENCE;
        end else if (freq_sat) begin
            result = NOTE_UNKNOWN;
        end else if (found) begin
            result = match_idx;
        end else if (hit) begin
            result = scan_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state      <= ST_IDLE;
            scan_i     <= '0;
            found      <= 1'b0;
            match_idx  <= '0;
            cur_idx    <= NOTE_SILENCE;
            run_ms     <= '0;
            note_idx   <= NOTE_SILENCE;
            cls_valid  <= 1'b0;
            evt_valid  <= 1'b0;
            evt_idx    <= NOTE_SILENCE;
            evt_dur_ms <= '0;
        end else begin
            cls_valid <= 1'b0;
            evt_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gate_end) begin
                        state  <= ST_SCAN;
                        scan_i <= '0;
                        found  <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (hit && !found) begin
                        found     <= 1'b1;
                        match_idx <= scan_i;
                    end
                    if (scan_last) begin
                        // Outputs registered here are visible during REPORT.
                        state     <= ST_REPORT;
                        note_idx  <= result;
                        cls_valid <= 1'b1;
                        if (result == cur_idx) begin
                            run_ms <= run_inc;
                        end else begin
                            if (run_ms != 16'd0) begin
                                evt_valid  <= 1'b1;
                                evt_idx    <= cur_idx;
                                evt_dur_ms <= run_ms;
                            end
                            cur_idx <= result;
                            run_ms  <= 16'(GATE_MS);
                        end
                    end else begin
                        scan_i <= scan_i + 5'd1;
                    end
                end
                ST_REPORT: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder with a short 1 ms gate at 3 MHz so that each
// gate is 3000 clocks; per-gate edge counts and expected results are tabulated.
module tb_tone_decoder;

    localparam int CLK_MHZ = 3;
    localparam int GATE_MS = 1;
    localparam int TOL_HZ  = 47;
    localparam int G       = CLK_MHZ * 1000 * GATE_MS;
    localparam int NG      = 16;

    logic        clk = 1'b0;
    logic        reset_p = 1'b1;
    logic        song_in = 1'b0;
    logic [13:0] freq_hz;
    logic        freq_valid;
    logic        freq_sat;
    logic [4:0]  note_idx;
    logic        cls_valid;
    logic        evt_valid;
    logic [4:0]  evt_idx;
    logic [15:0] evt_dur_ms;

    int total = 0;
    int bad   = 0;
    int rel   = 0;
    int gbase = 0;
    logic [4:0] exp_q[$];

    // Per gate: rising edges to drive (-1 = toggle every clock), expected
    // frequency (edges * 1000, 14-bit), saturation, note and the event it closes.
    int tb_n    [NG] = '{0, 0, 1, 1, 2, 3, 3, 3, 4, 5, -1, 2, 0, 2, 1, 0};
    int tb_freq [NG] = '{0, 0, 1000, 1000, 2000, 3000, 3000, 3000, 4000, 5000, 7192, 2000, 0, 2000, 1000, 0};
    int tb_sat  [NG] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    int tb_note [NG] = '{31, 31, 0, 0, 11, 18, 18, 18, 30, 30, 30, 11, 31, 11, 0, 31};
    int tb_evt  [NG] = '{0, 0, 1, 0, 1, 1, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0};
    int tb_eidx [NG] = '{0, 0, 31, 0, 0, 11, 0, 0, 18, 0, 0, 30, 11, 0, 0, 0};
    int tb_edur [NG] = '{0, 0, 2, 0, 2, 1, 0, 0, 3, 0, 0, 3, 1, 0, 0, 0};

    tone_decoder #(
        .CLK_MHZ(CLK_MHZ),
        .GATE_MS(GATE_MS),
        .TOL_HZ (TOL_HZ)
    ) dut (
        .clk       (clk),
        .reset_p   (reset_p),
        .song_in   (song_in),
        .freq_hz   (freq_hz),
        .freq_valid(freq_valid),
        .freq_sat  (freq_sat),
        .note_idx  (note_idx),
        .cls_valid (cls_valid),
        .evt_valid (evt_valid),
        .evt_idx   (evt_idx),
        .evt_dur_ms(evt_dur_ms)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (rel cycle %0d)", tag, got, exp, rel);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_freq_hz", freq_hz, 0);
        check("rst_freq_valid", freq_valid, 0);
        check("rst_freq_sat", freq_sat, 0);
        check("rst_note_idx", note_idx, 31);
        check("rst_cls_valid", cls_valid, 0);
        check("rst_evt_valid", evt_valid, 0);
        check("rst_evt_idx", evt_idx, 31);
        check("rst_evt_dur", evt_dur_ms, 0);
    endtask

    // Gate k closes on rel cycle k*G-1: freq at k*G, class/event at k*G+24.
    task automatic check_cycle();
        bit exp_fv;
        bit exp_cls;
        bit exp_evt;
        int g;
        exp_fv  = (rel > 0) && (rel % G == 0);
        exp_cls = (rel >= G) && (rel % G == 24);
        g       = gbase + rel / G - 1;
        exp_evt = 1'b0;
        if (exp_cls) exp_evt = (tb_evt[g] != 0);

        if (freq_valid || exp_fv) check("freq_valid", freq_valid, exp_fv);
        if (exp_fv) begin
            check("freq_hz", freq_hz, tb_freq[g]);
            check("freq_sat", freq_sat, tb_sat[g]);
            exp_q.push_back(5'(tb_note[g]));
        end

        if (cls_valid || exp_cls) check("cls_valid", cls_valid, exp_cls);
        if (exp_cls) begin
            check("note_q_depth", exp_q.size(), 1);
            if (exp_q.size() > 0) check("note_idx", note_idx, exp_q.pop_front());
        end

        if (evt_valid || exp_evt) check("evt_valid", evt_valid, exp_evt);
        if (exp_evt) begin
            check("evt_idx", evt_idx, tb_eidx[g]);
            check("evt_dur_ms", evt_dur_ms, tb_edur[g]);
        end
    endtask

    task automatic drive_cycle();
        int g;
        int p;
        g = gbase + rel / G;
        p = rel % G;
        if (tb_n[g] < 0) begin
            song_in = (p >= 10 && p < G - 10) ? ~song_in : 1'b0;
        end else begin
            song_in = 1'b0;
            for (int k = 0; k < tb_n[g]; k++) begin
                if (p >= 100 + k * 500 && p < 150 + k * 500) song_in = 1'b1;
            end
        end
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            check_cycle();
            drive_cycle();
            @(negedge clk);
            rel++;
        end
    endtask

    initial begin
        reset_p = 1'b1;
        song_in = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset_p = 1'b0;
        rel     = 0;
        gbase   = 0;
        check_reset_vals();

        // Gates 0..12 complete; gate 13 is cut by reset ten cycles after its end.
        run_cycles(14 * G + 9);
        reset_p = 1'b1;
        song_in = 1'b0;
        @(negedge clk);
        check_reset_vals();
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("hold_cls_valid", cls_valid, 0);
        check("hold_evt_valid", evt_valid, 0);
        reset_p = 1'b0;
        rel     = 0;
        gbase   = 14;
        check_reset_vals();
        run_cycles(G + 30);

        check("note_q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
